// File: rtl/lwsw_violation_logger.sv
// lwsw_violation_logger
//   Captures rising edges of the four lwsw LTL monitor violation flags,
//   timestamps each one and queues it in a small FIFO for a consumer to
//   drain. It also keeps a sticky per-property summary, an overflow flag
//   and a saturating count of records lost because the FIFO was full.
//
// Parameters
//   DEPTH     FIFO entries (power of two, 2..16)
//   TS_W      timestamp width in bits
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-low; clears all state
//   run        monitor enable (same signal as the LTL monitor stage)
//   ltl_flags  per-property violation flags, bit0=ltl0 .. bit3=ltl3
//   clr        synchronous clear of status, counters, timestamp and FIFO
//   rec_valid  head FIFO record is valid
//   rec_ready  consumer accepts the head record
//   rec_flags  newly-risen flags of the head record
//   rec_time   timestamp of the head record
//   sticky     OR of every flag seen since reset/clr
//   overflow   sticky; a record was dropped on a full FIFO
//   drop_cnt   saturating count of dropped records

module lwsw_violation_logger #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [3:0]      ltl_flags,
  input  logic            clr,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [3:0]      rec_flags,
  output logic [TS_W-1:0] rec_time,
  output logic [3:0]      sticky,
  output logic            overflow,
  output logic [7:0]      drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = 4 + TS_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [TS_W-1:0] ts;
  logic [3:0]      flags_prev;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [RW-1:0]   mem [DEPTH];

  logic [3:0]      new_flags;
  logic            rec_event;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  // Event detection and FIFO handshake decisions. A pop on a full FIFO
  // frees the slot the simultaneous push lands in, so no drop happens.
  always_comb begin
    new_flags = ltl_flags & ~flags_prev & {4{run}};
    rec_event = |new_flags;
    full      = (count == FULL_CNT);
    pop       = rec_valid & rec_ready;
    push      = rec_event & (~full | pop);
    drop      = rec_event & full & ~pop;
  end

  // Head record presentation; forced to zero when empty so the outputs
  // read zero straight out of reset regardless of storage contents.
  always_comb begin
    rec_valid = (count != '0);
    rec_flags = '0;
    rec_time  = '0;
    if (rec_valid) begin
      rec_flags = mem[rd_ptr][RW-1:TS_W];
      rec_time  = mem[rd_ptr][TS_W-1:0];
    end
  end

  // Record storage. When full with a pop, wr_ptr equals rd_ptr; the head
  // is consumed this cycle and its slot is reused by the new record,
  // which ends up last in order.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= {new_flags, ts};
    end
  end

  // Control state: timestamp, edge-detect history, pointers, occupancy
  // and status. clr wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts         <= '0;
      flags_prev <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sticky     <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else if (clr) begin
      ts         <= '0;
      flags_prev <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sticky     <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (run) begin
        ts <= ts + TS_W'(1);
      end
      flags_prev <= run ? ltl_flags : 4'h0;
      sticky     <= sticky | (ltl_flags & {4{run}});

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lwsw_violation_logger.sv
// tb_lwsw_violation_logger
//   Self-checking bench for lwsw_violation_logger (DEPTH=4, TS_W=16).
//   A queue-based reference model tracks records, timestamp and status;
//   a directed vector table, hand-written corner sequences and random
//   cycles are all compared against it and against fixed expectations.

module tb_lwsw_violation_logger;

  localparam int DEPTH = 4;
  localparam int TS_W  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            run;
  logic [3:0]      ltl_flags;
  logic            clr;
  logic            rec_valid;
  logic            rec_ready;
  logic [3:0]      rec_flags;
  logic [TS_W-1:0] rec_time;
  logic [3:0]      sticky;
  logic            overflow;
  logic [7:0]      drop_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lwsw_violation_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .ltl_flags (ltl_flags),
    .clr       (clr),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_flags (rec_flags),
    .rec_time  (rec_time),
    .sticky    (sticky),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  // Reference model state
  typedef struct {
    logic [3:0]      f;
    logic [TS_W-1:0] t;
  } rec_t;

  rec_t       mq[$];
  logic [3:0] m_prev;
  logic [3:0] m_sticky;
  logic       m_ovf;
  int         m_drop;
  int         m_ts;

  function automatic void modelReset();
    mq.delete();
    m_prev   = 4'h0;
    m_sticky = 4'h0;
    m_ovf    = 1'b0;
    m_drop   = 0;
    m_ts     = 0;
  endfunction

  function automatic void modelStep(input logic r, input logic [3:0] f,
                                    input logic rdy, input logic c);
    logic [3:0] nf;
    rec_t       tmp;
    if (c) begin
      modelReset();
      return;
    end
    nf = r ? (f & ~m_prev) : 4'h0;
    if (mq.size() > 0 && rdy) begin
      void'(mq.pop_front());
    end
    if (nf != 4'h0) begin
      if (mq.size() < DEPTH) begin
        tmp.f = nf;
        tmp.t = m_ts[TS_W-1:0];
        mq.push_back(tmp);
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    m_sticky = m_sticky | (r ? f : 4'h0);
    m_prev   = r ? f : 4'h0;
    if (r) m_ts = (m_ts + 1) % (1 << TS_W);
  endfunction

  task automatic compareVal(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the reference model
  task automatic checkOutput();
    logic [3:0]      ef;
    logic [TS_W-1:0] et;
    ef = 4'h0;
    et = '0;
    if (mq.size() > 0) begin
      ef = mq[0].f;
      et = mq[0].t;
    end
    compareVal("rec_valid", 32'(rec_valid), 32'(mq.size() != 0));
    compareVal("rec_flags", 32'(rec_flags), 32'(ef));
    compareVal("rec_time",  32'(rec_time),  32'(et));
    compareVal("sticky",    32'(sticky),    32'(m_sticky));
    compareVal("overflow",  32'(overflow),  32'(m_ovf));
    compareVal("drop_cnt",  32'(drop_cnt),  32'(m_drop));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // optionally check outputs 1 time unit after the edge
  task automatic applyStimulus(input logic r, input logic [3:0] f,
                               input logic rdy, input logic c,
                               input bit chk = 1'b1);
    run       = r;
    ltl_flags = f;
    rec_ready = rdy;
    clr       = c;
    @(posedge clk);
    modelStep(r, f, rdy, c);
    #1;
    if (chk) checkOutput();
  endtask

  typedef struct {
    logic            r;
    logic [3:0]      f;
    logic            rdy;
    logic            v;
    logic [3:0]      ef;
    logic [TS_W-1:0] et;
    logic [3:0]      es;
  } vec_t;

  vec_t vt [13];

  logic [3:0]      pat   [6];
  logic [3:0]      dflag [4];
  logic [TS_W-1:0] dtime [4];

  initial begin
    // Directed table: first event at ts=5, held flag, ready stall, run gap
    vt[0]  = '{1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 16'd0,  4'h0};
    vt[1]  = '{1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 16'd0,  4'h0};
    vt[2]  = '{1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 16'd0,  4'h0};
    vt[3]  = '{1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 16'd0,  4'h0};
    vt[4]  = '{1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 16'd0,  4'h0};
    vt[5]  = '{1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 16'd5,  4'h1};
    vt[6]  = '{1'b1, 4'h1, 1'b1, 1'b0, 4'h0, 16'd0,  4'h1};
    vt[7]  = '{1'b1, 4'h1, 1'b1, 1'b0, 4'h0, 16'd0,  4'h1};
    vt[8]  = '{1'b1, 4'h3, 1'b0, 1'b1, 4'h2, 16'd8,  4'h3};
    vt[9]  = '{1'b1, 4'h3, 1'b0, 1'b1, 4'h2, 16'd8,  4'h3};
    vt[10] = '{1'b0, 4'h3, 1'b0, 1'b1, 4'h2, 16'd8,  4'h3};
    vt[11] = '{1'b1, 4'h3, 1'b1, 1'b1, 4'h3, 16'd10, 4'h3};
    vt[12] = '{1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 16'd0,  4'h3};

    pat[0] = 4'h1; pat[1] = 4'h2; pat[2] = 4'h4;
    pat[3] = 4'h8; pat[4] = 4'h1; pat[5] = 4'h2;

    dflag[0] = 4'h2; dtime[0] = 16'd2;
    dflag[1] = 4'h4; dtime[1] = 16'd4;
    dflag[2] = 4'h8; dtime[2] = 16'd6;
    dflag[3] = 4'h4; dtime[3] = 16'd12;

    // Reset state
    reset     = 1'b0;
    run       = 1'b0;
    ltl_flags = 4'h0;
    clr       = 1'b0;
    rec_ready = 1'b0;
    modelReset();
    #1;
    compareVal("reset rec_valid", 32'(rec_valid), 32'd0);
    compareVal("reset drop_cnt",  32'(drop_cnt),  32'd0);
    #11;
    reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vt[i].r, vt[i].f, vt[i].rdy, 1'b0);
      compareVal($sformatf("vec%0d valid", i), 32'(rec_valid), 32'(vt[i].v));
      compareVal($sformatf("vec%0d flags", i), 32'(rec_flags), 32'(vt[i].ef));
      compareVal($sformatf("vec%0d time", i),  32'(rec_time),  32'(vt[i].et));
      compareVal($sformatf("vec%0d sticky", i), 32'(sticky),   32'(vt[i].es));
    end

    // Overflow: six rising events into a stalled 4-deep FIFO
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, pat[i], 1'b0, 1'b0);
      applyStimulus(1'b1, 4'h0,   1'b0, 1'b0);
    end
    compareVal("ovf overflow",  32'(overflow),  32'd1);
    compareVal("ovf drop_cnt",  32'(drop_cnt),  32'd2);
    compareVal("ovf head flags", 32'(rec_flags), 32'h1);
    compareVal("ovf head time",  32'(rec_time),  32'd0);

    // Full FIFO with simultaneous pop and event
    applyStimulus(1'b1, 4'h4, 1'b1, 1'b0);
    compareVal("fullpop drop_cnt", 32'(drop_cnt), 32'd2);
    for (int k = 0; k < 4; k++) begin
      compareVal($sformatf("drain%0d valid", k), 32'(rec_valid), 32'd1);
      compareVal($sformatf("drain%0d flags", k), 32'(rec_flags), 32'(dflag[k]));
      compareVal($sformatf("drain%0d time", k),  32'(rec_time),  32'(dtime[k]));
      applyStimulus(1'b1, 4'h0, 1'b1, 1'b0);
    end
    compareVal("drain empty", 32'(rec_valid), 32'd0);

    // clr with three queued records and a same-cycle event
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h4, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h8, 1'b0, 1'b1);
    compareVal("clr rec_valid", 32'(rec_valid), 32'd0);
    compareVal("clr sticky",    32'(sticky),    32'd0);
    compareVal("clr overflow",  32'(overflow),  32'd0);
    compareVal("clr drop_cnt",  32'(drop_cnt),  32'd0);

    // Timestamp wrap
    applyStimulus(1'b1, 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    compareVal("wrap first time", 32'(rec_time), 32'hFFFF);
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b1, 1'b0);
    compareVal("wrap second flags", 32'(rec_flags), 32'h2);
    compareVal("wrap second time",  32'(rec_time),  32'h0);

    // Asynchronous reset with a record pending, no clock edge involved
    compareVal("pre-reset valid", 32'(rec_valid), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    modelReset();
    compareVal("async valid", 32'(rec_valid), 32'd0);
    compareVal("async flags", 32'(rec_flags), 32'd0);
    compareVal("async time",  32'(rec_time),  32'd0);
    compareVal("async sticky", 32'(sticky),   32'd0);
    #1;
    reset = 1'b1;
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
    compareVal("post-reset flags", 32'(rec_flags), 32'hF);
    compareVal("post-reset time",  32'(rec_time),  32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 9) != 0),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 59) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lwsw_violation_logger.md
LWSW_VIOLATION_LOGGER -- requirements
Module: lwsw_violation_logger

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 Parameter TS_W, default 16, timestamp width in bits.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low; asserting low clears all state immediately.
REQ-005 Port run  input  1  monitor-enable, same signal that drives the LTL monitor stage.
REQ-006 Port ltl_flags  input  4  per-property violation flags from the lwsw monitor; bit0=ltl0 .. bit3=ltl3.
REQ-007 Port clr  input  1  synchronous clear of sticky status, counters, timestamp and FIFO.
REQ-008 Port rec_valid  output  1  head FIFO record is valid.
REQ-009 Port rec_ready  input  1  consumer accepts the head record when high with rec_valid.
REQ-010 Port rec_flags  output  4  newly-risen flags of the head record.
REQ-011 Port rec_time  output  TS_W  timestamp of the head record.
REQ-012 Port sticky  output  4  per-property OR of every flag seen since reset/clr.
REQ-013 Port overflow  output  1  sticky; set when a record is dropped because the FIFO is full.
REQ-014 Port drop_cnt  output  8  saturating count of dropped records.

Function
REQ-015 ts counter: +1 each cycle run=1; holds when run=0; wraps all-ones -> 0.
REQ-016 flags_prev register: loads ltl_flags each cycle run=1; loads 0 when run=0.
REQ-017 new = ltl_flags & ~flags_prev & {4{run}}; a record event occurs when new != 0.
REQ-018 Record contents: rec_flags = new, rec_time = ts value in the event cycle (before increment).
REQ-019 Event pushes one record at the next clock edge; rec_valid rises 1 cycle after the event when the FIFO was empty.
REQ-020 Pop occurs on any edge with rec_valid=1 and rec_ready=1; the next record is presented on the following cycle.
REQ-021 rec_flags/rec_time stay stable while rec_valid=1 and rec_ready=0.
REQ-022 FIFO output order equals event order; no reordering or merging.
REQ-023 Full (DEPTH entries) with no pop: event is dropped; overflow<=1; drop_cnt+1, saturating at 255.
REQ-024 Full with a simultaneous pop and event: both happen; no drop; occupancy unchanged.
REQ-025 Empty with an event: push only; the same cycle never shows the new record; no underflow on rec_ready without rec_valid.
REQ-026 sticky <= sticky | (ltl_flags & {4{run}}) each cycle.
REQ-027 clr=1: FIFO emptied, rec_valid 0, sticky/overflow/drop_cnt/ts/flags_prev <= 0; an event in the same cycle is discarded; clr beats push and pop.
REQ-028 Pointers are log2(DEPTH) bits plus a count register 0..DEPTH; wrap-around is transparent.

Reset
REQ-029 reset low sets rec_valid, rec_flags, rec_time, sticky, overflow, drop_cnt, ts, flags_prev, pointers and count to 0, asynchronously.
REQ-030 reset low mid-transfer discards all queued records; after release, the first event yields a record at ts=0-based time.
REQ-031 After reset release, the first active clock edge performs normal operation; no extra settle cycles.

Verification
REQ-032 run=1, ltl_flags 0->0x1 at ts=5, rec_ready=1 -> next cycle rec_valid=1, rec_flags=0x1, rec_time=5; one record only while flag held.
REQ-033 DEPTH=4, rec_ready=0, 6 distinct rising events -> 4 records kept in order, overflow=1, drop_cnt=2.
REQ-034 FIFO full, rec_ready=1 and a new event in the same cycle -> drop_cnt unchanged, count stays 4, new record last in order.
REQ-035 ts preset by running 65535 cycles, event -> rec_time=0xFFFF; next event next cycle -> rec_time=0x0000.
REQ-036 3 queued records, clr=1 together with an event -> next cycle rec_valid=0, sticky=0, overflow=0, drop_cnt=0.
REQ-037 reset asserted low with rec_valid=1 and no clock edge -> all outputs 0 immediately; ltl_flags=0xF after release -> rec_flags=0xF.
